// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative signed divider.
// Latency: n/a (package).  Backpressure: n/a (package).
package divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int calc_cycles(input int width);
        return 2 * width;
    endfunction

    localparam int CALC_CYCLES = calc_cycles(DEFAULT_WIDTH);
    localparam int DZ_LATENCY  = 2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.  Backpressure: none.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] rem_cur,
    input  logic           dvd_bit,
    input  logic [WIDTH:0] dvsr_mag,
    output logic [WIDTH:0] rem_next,
    output logic           q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem_cur, dvd_bit};
        diff     = shifted - {1'b0, dvsr_mag};
        q_bit    = ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/sequential_divider.sv
// Signed 2W/W restoring divider, one quotient bit per clock, with sign and overflow fix-up.
// Latency: done in the 2W+2nd cycle counting the accept cycle; 2nd for divide by zero.
// Backpressure: start ignored while busy (including the done cycle); no stall once accepted.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 overflow,
    output logic                 div_by_zero
);

    localparam int CALC_N = calc_cycles(WIDTH);
    localparam int CNT_W  = $clog2(CALC_N + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(CALC_N - 1);

    state_t             state;
    logic [CNT_W-1:0]   iter_cnt;
    logic [WIDTH:0]     prem;
    logic [WIDTH:0]     dvsr_mag;
    logic [2*WIDTH-1:0] dvd_q;
    logic               sign_dvd;
    logic               neg_quot;
    logic               dz_pend;

    logic [WIDTH:0]     prem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] dvd_abs;
    logic [WIDTH:0]     dvsr_ext;
    logic [WIDTH:0]     dvsr_abs;
    logic [2*WIDTH-1:0] q_fix;
    logic [WIDTH:0]     q_hi;
    logic               q_ovf;
    logic [WIDTH-1:0]   r_fix;

    // Divisor magnitude is WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
    always_comb begin
        dvd_abs  = dividend[2*WIDTH-1] ? -dividend : dividend;
        dvsr_ext = {divisor[WIDTH-1], divisor};
        dvsr_abs = dvsr_ext[WIDTH] ? -dvsr_ext : dvsr_ext;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_cur  (prem),
        .dvd_bit  (dvd_q[2*WIDTH-1]),
        .dvsr_mag (dvsr_mag),
        .rem_next (prem_next),
        .q_bit    (q_bit)
    );

    // Quotient fits iff its top WIDTH+1 bits are a pure sign extension.
    always_comb begin
        q_fix = neg_quot ? -dvd_q : dvd_q;
        q_hi  = q_fix[2*WIDTH-1:WIDTH-1];
        q_ovf = ~((&q_hi) | ~(|q_hi));
        r_fix = sign_dvd ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            prem        <= '0;
            dvsr_mag    <= '0;
            dvd_q       <= '0;
            sign_dvd    <= 1'b0;
            neg_quot    <= 1'b0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy        <= 1'b1;
                        sign_dvd    <= dividend[2*WIDTH-1];
                        neg_quot    <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        dvd_q       <= dvd_abs;
                        dvsr_mag    <= dvsr_abs;
                        prem        <= '0;
                        iter_cnt    <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        dz_pend     <= (divisor == '0);
                        state       <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    // Quotient bits shift into the vacated low end of the dividend register.
                    prem     <= prem_next;
                    dvd_q    <= {dvd_q[2*WIDTH-2:0], q_bit};
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz_pend) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_fix[WIDTH-1:0];
                        remainder   <= r_fix;
                        overflow    <= q_ovf;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
- Iterative signed divider; the inverse of the team's combinational signed multiplier.
- Takes a 2*WIDTH-bit signed dividend (multiplier product width) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit quotient and remainder using a shift-subtract restoring algorithm, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit, with a start/busy/done handshake.

Parameters:
- WIDTH, 32: operand width. Dividend is 2*WIDTH; quotient and remainder are WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  2*WIDTH  signed dividend; latched when start is accepted.
- divisor  in  WIDTH  signed divisor; latched when start is accepted.
- busy  out  1  high while an operation is in progress (CALC/FIX).
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; sign follows the dividend.
- overflow  out  1  true quotient is outside the signed WIDTH range.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, quotient, remainder, overflow, div_by_zero all 0; iteration counter 0.
- States and transitions:
  - IDLE -> CALC on start with divisor!=0.
  - IDLE -> FIX on start with divisor==0.
  - CALC -> FIX after 2*WIDTH iterations.
  - FIX -> IDLE.
- Accept (IDLE && start):
  - Latch the sign of dividend and the sign of divisor.
  - Latch magnitudes |dividend| (2*WIDTH bits) and |divisor| (WIDTH+1 bits, so -2^(WIDTH-1) is representable).
  - Clear the partial remainder; counter=0.
  - Clear overflow and div_by_zero.
- CALC, one iteration per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract |divisor| from the partial remainder. If the result is non-negative, keep it and set quotient bit=1; otherwise restore and set 0.
  - Partial remainder is WIDTH+1 bits; quotient magnitude is 2*WIDTH bits.
- FIX (one cycle):
  - Apply signs: quotient negative iff the operand signs differ; remainder takes the dividend sign.
  - overflow=1 if the signed 2*WIDTH quotient is < -2^(WIDTH-1) or > 2^(WIDTH-1)-1. On overflow, quotient = low WIDTH bits of the true quotient; remainder is still exact.
  - Divide by zero: quotient=0, remainder=0, overflow=0, div_by_zero=1.
  - done=1 on the cycle the registers update.
- Latency: start-accept edge to done-high is 2*WIDTH+2 cycles normally (66 for WIDTH=32), and 2 cycles for divide by zero.
- busy is high from the cycle after accept until and including the done cycle.
- quotient, remainder, overflow and div_by_zero hold their values until the next accepted start.
- done is low in every cycle other than the completion cycle.
- start while busy is ignored; the operands are not re-latched.
- start asserted in the done cycle is not accepted; it is accepted the following cycle in IDLE.
- Boundary values:
  - divisor = -2^(WIDTH-1) is handled exactly.
  - dividend = -2^(2*WIDTH-1) has magnitude 2^(2*WIDTH-1), which fits unsigned.
  - A zero dividend gives quotient=0 and remainder=0, with normal latency.
- Reset mid-CALC aborts the operation immediately; no done is issued.

Decomposition:
- Package divider_pkg:
  - state enum {IDLE, CALC, FIX};
  - DEFAULT_WIDTH=32;
  - latency constants CALC_CYCLES=2*WIDTH and DZ_LATENCY=2.
- Sub-module div_step: combinational single iteration.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
  - The top level holds the FSM, registers, and sign/overflow fix-up.

Test Plan:
1. dividend=-11, divisor=5 -> after 66 cycles done=1; quotient=-2, remainder=-1, overflow=0.
2. dividend=220, divisor=-11 -> quotient=-20, remainder=0. Then dividend=-63, divisor=-3 -> quotient=21, remainder=0. Check busy is high for exactly 66 cycles and done is a single pulse each time.
3. dividend=-4611686016279904256, divisor=-2147483648 -> quotient=2147483647, remainder=0. Then dividend=8589934592, divisor=-4 -> quotient=-2147483648, overflow=0.
4. dividend=8589934592, divisor=2 -> overflow=1, quotient=0 (low 32 bits of 4294967296), remainder=0.
5. dividend=100, divisor=0 -> done 2 cycles after accept; div_by_zero=1, quotient=0, remainder=0. The next valid operation clears div_by_zero.
6. Robustness sequence:
   - Pulse start mid-CALC with different operands -> the result matches the original operands.
   - Assert rst at iteration 10 -> all outputs 0 immediately, and no done pulse.
   - Then 12/5 -> quotient=2, remainder=2.
